// File: rtl/sram_byte_responder.sv
// sram_byte_responder: accepts byte/half/word load/store requests from the core,
// checks size, alignment and range, and runs each access as byte cycles on an
// 8-bit asynchronous SRAM. Completion is a one-cycle ready pulse plus a fault code.
module sram_byte_responder #(
   parameter int ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable_n,
   input  logic                 is_write,
   input  logic                 is_unsigned,
   input  logic [1:0]           op_size,
   input  logic [31:0]          addr,
   input  logic [31:0]          in,
   output logic [31:0]          out,
   output logic [2:0]           fault_num,
   output logic                 ready,
   output logic [ADDR_BITS-1:0] sram_addr,
   input  logic [7:0]           sram_data_in,
   output logic [7:0]           sram_data_out,
   output logic                 sram_data_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n
);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_BAD  = 2'b11;

   localparam logic [2:0] F_NONE   = 3'd0;
   localparam logic [2:0] F_LD_MIS = 3'd1;
   localparam logic [2:0] F_LD_ACC = 3'd2;
   localparam logic [2:0] F_ST_MIS = 3'd3;
   localparam logic [2:0] F_ST_ACC = 3'd4;
   localparam logic [2:0] F_SIZE   = 3'd5;

   typedef enum logic [1:0] {IDLE, XFER, DONE, HOLD} state_t;

   state_t               state_reg;
   logic                 is_write_reg;
   logic                 is_unsigned_reg;
   logic [1:0]           size_reg;
   logic [ADDR_BITS-1:0] base_reg;
   logic [31:0]          wdata_reg;
   logic [1:0]           idx_reg;

   logic [7:0]           wdata_byte [4];
   logic [1:0]           idx_next;
   logic [1:0]           idx_last;
   logic [2:0]           req_fault;
   logic                 misaligned;
   logic                 out_of_range;
   logic                 ext_bit;

   // Little-endian lanes of the latched store data, lane k goes out on byte cycle k.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata_byte[gi] = wdata_reg[8*gi +: 8];
      end
   endgenerate

   assign idx_next = idx_reg + 2'd1;
   assign idx_last = (size_reg == SIZE_WORD) ? 2'd3 :
                     (size_reg == SIZE_HALF) ? 2'd1 : 2'd0;
   // The byte being captured on the final cycle carries the sign of the result.
   assign ext_bit  = ~is_unsigned_reg & sram_data_in[7];

   // Classify the incoming request: invalid size beats misalignment beats range.
   always_comb begin
      misaligned   = ((op_size == SIZE_HALF) && addr[0]) ||
                     ((op_size == SIZE_WORD) && (addr[1:0] != 2'b00));
      out_of_range = (addr >> ADDR_BITS) != 32'd0;
      if (op_size == SIZE_BAD)
         req_fault = F_SIZE;
      else if (misaligned)
         req_fault = is_write ? F_ST_MIS : F_LD_MIS;
      else if (out_of_range)
         req_fault = is_write ? F_ST_ACC : F_LD_ACC;
      else
         req_fault = F_NONE;
   end

   // Request FSM with all outputs registered so SRAM pins only move on clk edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         out             <= 32'd0;
         fault_num       <= F_NONE;
         ready           <= 1'b0;
         sram_addr       <= '0;
         sram_data_out   <= 8'd0;
         sram_data_oe    <= 1'b0;
         sram_ce_n       <= 1'b1;
         sram_oe_n       <= 1'b1;
         sram_we_n       <= 1'b1;
         is_write_reg    <= 1'b0;
         is_unsigned_reg <= 1'b0;
         size_reg        <= SIZE_BYTE;
         base_reg        <= '0;
         wdata_reg       <= 32'd0;
         idx_reg         <= 2'd0;
      end else begin
         ready <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!enable_n) begin
                  is_write_reg    <= is_write;
                  is_unsigned_reg <= is_unsigned;
                  size_reg        <= op_size;
                  base_reg        <= addr[ADDR_BITS-1:0];
                  wdata_reg       <= in;
                  idx_reg         <= 2'd0;
                  fault_num       <= req_fault;
                  if (req_fault != F_NONE) begin
                     // Faults never touch the SRAM and leave out untouched.
                     state_reg <= DONE;
                     ready     <= 1'b1;
                  end else begin
                     state_reg <= XFER;
                     sram_addr <= addr[ADDR_BITS-1:0];
                     sram_ce_n <= 1'b0;
                     if (is_write) begin
                        sram_we_n     <= 1'b0;
                        sram_data_oe  <= 1'b1;
                        sram_data_out <= in[7:0];
                     end else begin
                        sram_oe_n <= 1'b0;
                     end
                  end
               end
            end
            XFER: begin
               if (!is_write_reg)
                  out[8*idx_reg +: 8] <= sram_data_in;
               if (idx_reg == idx_last) begin
                  state_reg    <= DONE;
                  ready        <= 1'b1;
                  sram_ce_n    <= 1'b1;
                  sram_oe_n    <= 1'b1;
                  sram_we_n    <= 1'b1;
                  sram_data_oe <= 1'b0;
                  if (!is_write_reg) begin
                     if (size_reg == SIZE_BYTE)
                        out[31:8] <= {24{ext_bit}};
                     else if (size_reg == SIZE_HALF)
                        out[31:16] <= {16{ext_bit}};
                  end
               end else begin
                  idx_reg   <= idx_next;
                  sram_addr <= base_reg + {{(ADDR_BITS-2){1'b0}}, idx_next};
                  if (is_write_reg)
                     sram_data_out <= wdata_byte[idx_next];
               end
            end
            DONE: begin
               state_reg <= HOLD;
            end
            HOLD: begin
               // A request still held low from the last access must not restart.
               if (enable_n)
                  state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
